// File: rtl/sdram_arb.sv
// sdram_arb: two-port word arbiter/sequencer in front of sdram_ctl; grant to ack ~9 cycles (read) / ~14 (write).
// Define SDRAM_ARB_RR_EN for round-robin grants; otherwise port 0 has fixed priority.
module sdram_arb #(
  parameter int INIT_CYCLES    = 5100,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [24:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [24:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic [15:0] p1_rdata,
  output logic        mem_write_en,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_start,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [5:0]    TO_LAST   = 6'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [5:0]    to_cnt_q, to_cnt_d;
  logic          grant_q, grant_d;
  logic          err_q, err_d;
  logic [15:0]   p0_rdata_q, p0_rdata_d;
  logic [15:0]   p1_rdata_q, p1_rdata_d;
  logic          mem_we_q, mem_we_d;
  logic [24:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;

  logic any_req;
  logic win;
  logic to_hit;

  assign any_req = p0_req | p1_req;
  assign to_hit  = (to_cnt_q == TO_LAST);

`ifdef SDRAM_ARB_RR_EN
  logic last_q, last_d;

  // On contention the port that did not win last time goes first.
  assign win = (p0_req && p1_req) ? ~last_q : ~p0_req;

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && any_req) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign win = ~p0_req;
`endif

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    to_cnt_d    = to_cnt_q;
    grant_d     = grant_q;
    err_d       = err_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (any_req) begin
          grant_d     = win;
          mem_we_d    = win ? p1_we    : p0_we;
          mem_addr_d  = win ? p1_addr  : p0_addr;
          mem_wdata_d = win ? p1_wdata : p0_wdata;
          to_cnt_d    = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == S_WAIT_BUSY && !mem_data_ready) begin
          state_d = S_WAIT_DONE;
        end else if (state_q == S_WAIT_DONE && mem_data_ready) begin
          if (grant_q) p1_rdata_d = mem_data_out;
          else         p0_rdata_d = mem_data_out;
          state_d = S_ACK;
        end else if (to_hit) begin
          // Hung controller: still complete the request, with a poison value.
          err_d = 1'b1;
          if (grant_q) p1_rdata_d = 16'hFFFF;
          else         p0_rdata_d = 16'hFFFF;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      to_cnt_q    <= '0;
      grant_q     <= 1'b0;
      err_q       <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      to_cnt_q    <= to_cnt_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_start    = (state_q == S_ISSUE);
  assign busy         = (state_q != S_IDLE);
  assign err          = err_q;
  assign p0_ack       = (state_q == S_ACK) && !grant_q;
  assign p1_ack       = (state_q == S_ACK) &&  grant_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;
  assign mem_write_en = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_wdata_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: behavioural sdram_ctl model plus per-port scoreboards of expected rdata and grant order.
module tb_sdram_arb;
  localparam int INIT = 300;
  localparam int TMO  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic        p0_we = 1'b0, p1_we = 1'b0;
  logic [24:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_write_en, mem_start, busy, err;
  logic [24:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_ready;

  always #5 clk = ~clk;

  sdram_arb #(.INIT_CYCLES(INIT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_start(mem_start), .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready),
    .busy(busy), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] e);
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, e);
    end
  endtask

  // Controller model: ready drops one cycle after it takes start, rises after the access.
  logic        hang = 1'b0;
  logic        ctl_busy;
  int          ctl_cnt;
  logic [15:0] ctl_mem [logic [24:0]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data_ready <= 1'b1;
      mem_data_out   <= '0;
      ctl_busy       <= 1'b0;
      ctl_cnt        <= 0;
    end else if (!ctl_busy) begin
      if (mem_start) begin
        ctl_busy <= 1'b1;
        ctl_cnt  <= mem_write_en ? 13 : 8;
      end
    end else begin
      mem_data_ready <= 1'b0;
      if (ctl_cnt != 0) begin
        ctl_cnt <= ctl_cnt - 1;
      end else if (!hang) begin
        ctl_busy       <= 1'b0;
        mem_data_ready <= 1'b1;
        if (mem_write_en) begin
          ctl_mem[mem_addr] = mem_data_in;
          mem_data_out <= mem_data_in;
        end else begin
          mem_data_out <= ctl_mem.exists(mem_addr) ? ctl_mem[mem_addr] : (mem_addr[15:0] ^ 16'h5A5A);
        end
      end
    end
  end

  // Scoreboard state
  logic [15:0] ref_mem [logic [24:0]];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int          grant_q [$];
  logic        force_ffff = 1'b0;

  function automatic logic [15:0] ref_rd(input logic [24:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return ref_mem.exists(a) ? ref_mem[a] : (lo ^ 16'h5A5A);
  endfunction

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int          first_start = -1;
  int          start_cyc   = 0;
  int          last_ack    = -1;
  int          starts      = 0;
  int          port, sz, g;
  logic        in_x   = 1'b0;
  logic        stable = 1'b1;
  logic [24:0] la;
  logic [15:0] ld, e, rd;
  logic        lw;

  always @(negedge clk) begin
    if (!rst) begin
      first_start = -1;
      last_ack    = -1;
      starts      = 0;
      in_x        = 1'b0;
    end else begin
      if (mem_start) begin
        if (first_start < 0) first_start = cyc;
        if (last_ack >= 0) chk("start_gap", 32'(cyc - last_ack >= 2), 1);
        starts++;
        start_cyc = cyc;
        in_x      = 1'b1;
        stable    = 1'b1;
        la = mem_addr; ld = mem_data_in; lw = mem_write_en;
      end else if (in_x && (mem_addr !== la || mem_data_in !== ld || mem_write_en !== lw)) begin
        stable = 1'b0;
      end
      if (p0_ack || p1_ack) begin
        port = p1_ack ? 1 : 0;
        chk("ack_onehot", 32'(p0_ack && p1_ack), 0);
        sz = (port == 0) ? exp_q0.size() : exp_q1.size();
        chk("ack_expected", 32'(sz > 0), 1);
        if (sz > 0) begin
          e  = (port == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          rd = (port == 0) ? p0_rdata : p1_rdata;
          chk("rdata", 32'(rd), 32'(e));
        end
        chk("mem_stable", 32'(stable), 1);
        chk("one_start", starts, 1);
        chk("ack_latency", 32'(cyc - start_cyc <= TMO + 3), 1);
        if (grant_q.size() > 0) begin
          g = grant_q.pop_front();
          chk("grant_order", port, g);
        end
        last_ack = cyc;
        starts   = 0;
        in_x     = 1'b0;
      end
    end
  end

  task automatic run_port(input int pn, input int n, input logic we, input logic [24:0] base,
                          input logic [15:0] wd, input int budget);
    for (int i = 0; i < n; i++) begin
      logic [24:0] a;
      logic [15:0] d, ex;
      logic        ak;
      int          k;
      a = base + 25'(i);
      d = wd + 16'(i);
      if (force_ffff) begin
        ex = 16'hFFFF;
      end else if (we) begin
        ex = d;
        ref_mem[a] = d;
      end else begin
        ex = ref_rd(a);
      end
      if (pn == 0) begin
        p0_we = we; p0_addr = a; p0_wdata = d; exp_q0.push_back(ex); p0_req = 1'b1;
      end else begin
        p1_we = we; p1_addr = a; p1_wdata = d; exp_q1.push_back(ex); p1_req = 1'b1;
      end
      k = 0;
      do begin
        @(negedge clk);
        k++;
        ak = (pn == 0) ? p0_ack : p1_ack;
      end while (!ak && k < budget);
      chk("ack_seen", 32'(ak), 1);
      @(posedge clk);
      #1;
      if (!ak) break;
    end
    if (pn == 0) p0_req = 1'b0;
    else         p1_req = 1'b0;
  endtask

  task automatic init_seq(input bit arb);
    rst = 1'b0;
    #1;
    chk("rst_p0_ack", 32'(p0_ack), 0);
    chk("rst_p1_ack", 32'(p1_ack), 0);
    chk("rst_p0_rdata", 32'(p0_rdata), 0);
    chk("rst_p1_rdata", 32'(p1_rdata), 0);
    chk("rst_start", 32'(mem_start), 0);
    chk("rst_we", 32'(mem_write_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_data_in), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_err", 32'(err), 0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    if (!arb) begin
      run_port(0, 1, 1'b0, 25'h0000040, 16'h0, INIT + 200);
    end else begin
`ifdef SDRAM_ARB_RR_EN
      grant_q = '{0, 1, 0, 1, 0, 1};
      fork
        run_port(0, 3, 1'b0, 25'h0000500, 16'h0, INIT + 500);
        run_port(1, 3, 1'b0, 25'h0000600, 16'h0, INIT + 500);
      join
`else
      grant_q = '{0, 0, 0, 0, 1, 1};
      fork
        run_port(0, 4, 1'b0, 25'h0000500, 16'h0, INIT + 500);
        run_port(1, 2, 1'b0, 25'h0000600, 16'h0, INIT + 500);
      join
`endif
      chk("grant_q_drained", grant_q.size(), 0);
    end
    chk("init_wait", 32'(first_start >= INIT && first_start <= INIT + 2), 1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    #2;
    init_seq(1'b0);

    // Write then read back the same word.
    run_port(0, 1, 1'b1, 25'h0000123, 16'hBEEF, 200);
    run_port(0, 1, 1'b0, 25'h0000123, 16'h0, 200);

    // p1 read in flight; p0 joins during WAIT_DONE and must wait for p1_ack.
    grant_q.push_back(1);
    grant_q.push_back(0);
    fork
      run_port(1, 1, 1'b0, 25'h0000300, 16'h0, 200);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!mem_start && k < 200);
        k = 0;
        do begin @(negedge clk); k++; end while (mem_data_ready && k < 50);
        @(posedge clk);
        #1;
        run_port(0, 1, 1'b0, 25'h0000301, 16'h0, 200);
      end
    join

    // Hung controller: timeout completes the request with poison data and a sticky err.
    hang = 1'b1;
    force_ffff = 1'b1;
    run_port(0, 1, 1'b0, 25'h0000200, 16'h0, 200);
    force_ffff = 1'b0;
    chk("err_set", 32'(err), 1);
    hang = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    run_port(0, 1, 1'b0, 25'h0000201, 16'h0, 200);
    chk("err_sticky", 32'(err), 1);

    // Reset while the controller is mid-access; the aborted request must never ack.
    p0_we = 1'b0; p0_addr = 25'h0000077; p0_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_start && k < 200);
    k = 0;
    do begin @(negedge clk); k++; end while (mem_data_ready && k < 50);
    chk("reached_wait", 32'(mem_data_ready), 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    init_seq(1'b1);

    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

endmodule
